hack_pc: RTL
============

Name: hack_pc

Overview:
- Program counter for the Hack CPU. It sits downstream of the 16-bit A-path multiplexer: the selected A value arrives as the jump target, and the current PC drives instruction-ROM address.
- Evaluates C-instruction jump conditions from ALU flags. Supports pipeline stall.
- Detects the Hack end-of-program idiom: repeated jumps to the block's own address.

Parameters:
WIDTH, 16, PC/target width in bits
RESET_VEC, 0, PC value loaded on reset
HALT_COUNT, 2, consecutive self-jumps required before halted asserts (legal range 1..15)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  1 = hold PC and all state this cycle
is_c  in  1  current instruction is a C-instruction (jump bits valid)
jmp  in  3  jump bits {j1,j2,j3} = {jump if <0, jump if =0, jump if >0}
zr  in  1  ALU output zero flag
ng  in  1  ALU output negative flag
target  in  WIDTH  jump target (A register value via 16-bit mux)
pc  out  WIDTH  current program counter (registered)
jumped  out  1  registered pulse: the previous update loaded target
halted  out  1  registered: program parked in a self-jump loop

Behaviour:
- Reset (rst_n=0 at rising edge): pc=RESET_VEC, jumped=0, halted=0, self-jump counter=0, FSM=RUN. Reset overrides stall and all other inputs. Reset held for multiple cycles keeps these values.
- Condition: pos = ~zr & ~ng. take = is_c & ((jmp[2]&ng) | (jmp[1]&zr) | (jmp[0]&pos)).
  - jmp=3'b111 always takes when is_c=1.
  - jmp=3'b000 never takes.
  - zr=ng=1 (illegal from ALU) is evaluated literally by the formula, with no special case.
- Update priority per cycle: reset > stall > take > increment.
  - stall=1: pc, jumped, halted and counter all hold their values.
  - take=1: pc <= target; jumped <= 1.
  - otherwise: pc <= pc+1 modulo 2^WIDTH; jumped <= 0. 16'hFFFF wraps to 16'h0000, with no flag.
- Latency: one cycle from inputs to the new pc. Combinational inputs are sampled at the edge; no input is registered internally.
- Self-jump detection:
  - self = take & (target == pc).
  - FSM states: RUN, HALT.
- RUN state:
  - On a non-stalled self cycle, counter <= counter+1, saturating at HALT_COUNT.
  - When the counter reaches HALT_COUNT (i.e. the HALT_COUNT-th consecutive self cycle), go to HALT and set halted <= 1 in that same edge.
  - A non-stalled non-self cycle clears the counter.
  - Stalled cycles do not break or advance the sequence.
- HALT state:
  - pc continues to follow the normal rules.
  - On any non-stalled non-self cycle: FSM=RUN, halted <= 0, counter <= 0.
  - Self cycles keep HALT.
- A jump to target==pc+1 is not a self-jump; jumped still pulses.
- Reset mid-sequence (RUN or HALT) discards counter and state immediately.

Test Plan:
1. Reset/increment: rst_n=0 for 2 cycles, then rst_n=1, is_c=0 for 5 cycles -> pc=0 during reset, then 1,2,3,4,5; jumped=0, halted=0 throughout.
2. Conditions: pc=10, target=16'h0040, is_c=1. Each jmp in 000..111 crossed with flags {zr=1,ng=0}, {zr=0,ng=1}, {zr=0,ng=0} -> pc=16'h0040 with jumped=1 exactly where the take formula is 1, else pc=11 with jumped=0. Repeat with is_c=0 -> never jumps.
3. Stall: pc=7, stall=1 with jmp=111, is_c=1 for 3 cycles -> pc stays 7, jumped unchanged. Release stall -> pc=target on the next edge.
4. Wrap: force pc to 16'hFFFE via a jump, then increment -> pc = FFFF, 0000, 0001; no jump pulse on the wrap.
5. Halt detect (HALT_COUNT=2): jump to 20, then target=20, jmp=111 held -> halted=1 after the 2nd self-jump edge, pc stays 20. Insert a stall between the self-jumps -> the sequence still counts. Then target=30 -> pc=30, halted=0 at the same edge.
6. Reset mid-halt: in HALT, assert rst_n=0 for one cycle -> pc=RESET_VEC, halted=0. Two further self-jumps are needed to re-halt.

Source files
------------

// File: rtl/hack_pc_if.sv
// Hack PC bus: control inputs from the CPU datapath and the PC outputs.
// The master (CPU side) drives the controls; the slave is the program counter.
interface hack_pc_if #(
   parameter int unsigned WIDTH = 16
);
   logic             stall;
   logic             is_c;
   logic [2:0]       jmp;
   logic             zr;
   logic             ng;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc;
   logic             jumped;
   logic             halted;

   modport master (
      output stall, is_c, jmp, zr, ng, target,
      input  pc, jumped, halted
   );

   modport slave (
      input  stall, is_c, jmp, zr, ng, target,
      output pc, jumped, halted
   );
endinterface

// File: rtl/hack_pc.sv
// Hack CPU program counter with jump-condition evaluation, stall and
// detection of the end-of-program idiom (repeated jumps to the current address).
module hack_pc #(
   parameter int unsigned      WIDTH      = 16,
   parameter logic [WIDTH-1:0] RESET_VEC  = '0,
   parameter int unsigned      HALT_COUNT = 2
) (
   input logic     clk,
   input logic     rst_n,
   hack_pc_if.slave bus
);
   typedef enum logic {RUN, HALT} state_t;

   localparam logic [3:0]       HALT_CNT = 4'(HALT_COUNT);
   localparam logic [WIDTH-1:0] PC_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic             r_jumped;
   logic             r_halted;
   logic             w_halted_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_nxt;
   logic [3:0]       w_cnt_inc;
   logic             w_pos;
   logic             w_take;
   logic             w_self;

   // zr=ng=1 cannot come from the ALU; the formula is applied as-is.
   assign w_pos     = ~bus.zr & ~bus.ng;
   assign w_take    = bus.is_c & ((bus.jmp[2] & bus.ng) | (bus.jmp[1] & bus.zr) | (bus.jmp[0] & w_pos));
   assign w_self    = w_take & (bus.target == r_pc);
   assign w_cnt_inc = r_cnt + 4'd1;

   always_comb begin
      // NOTE: every signal gets a default first, so no path can infer a latch.
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_halted_nxt = r_halted;
      unique case (r_state)
         RUN: begin
            if (w_self) begin
               if (w_cnt_inc >= HALT_CNT) begin
                  w_cnt_nxt    = HALT_CNT;
                  w_state_nxt  = HALT;
                  w_halted_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end else begin
               w_cnt_nxt = '0;
            end
         end
         HALT: begin
            if (!w_self) begin
               w_state_nxt  = RUN;
               w_cnt_nxt    = '0;
               w_halted_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
      if (!rst_n) begin
         r_pc     <= RESET_VEC;
         r_jumped <= 1'b0;
         r_halted <= 1'b0;
         r_cnt    <= '0;
         r_state  <= RUN;
      end else if (!bus.stall) begin
         r_pc     <= w_take ? bus.target : r_pc + PC_ONE;
         r_jumped <= w_take;
         r_halted <= w_halted_nxt;
         r_cnt    <= w_cnt_nxt;
         r_state  <= w_state_nxt;
      end
   end

   assign bus.pc     = r_pc;
   assign bus.jumped = r_jumped;
   assign bus.halted = r_halted;
endmodule
